// File: rtl/sensor_cmd_if.sv
// rtl/sensor_cmd_if.sv - scan-code input, sensor handshake and status bundle for sensor_cmd_scheduler
//
// Purpose: groups the keyboard strobe/byte, the two sensor enable/done handshakes
// and the status outputs of the scheduler into one interface.
// Signals:
//   datolisto  1-cycle strobe, tecla valid
//   tecla      8-bit scan code byte
//   temp_done  temperature front-end finished
//   humo_done  smoke front-end finished
//   tempenable level, high for the whole temperature op
//   humoenable level, high for the whole smoke op
//   busy       scheduler active or queue non-empty
//   cor        {ovf_sticky, tout_sticky, humoenable, tempenable}
// Modports: master drives stimulus/done and observes status, slave is the scheduler.

interface sensor_cmd_if;
    logic       datolisto;
    logic [7:0] tecla;
    logic       temp_done;
    logic       humo_done;
    logic       tempenable;
    logic       humoenable;
    logic       busy;
    logic [3:0] cor;

    modport master (
        output datolisto, tecla, temp_done, humo_done,
        input  tempenable, humoenable, busy, cor
    );

    modport slave (
        input  datolisto, tecla, temp_done, humo_done,
        output tempenable, humoenable, busy, cor
    );
endinterface

// File: rtl/sensor_cmd_scheduler.sv
// rtl/sensor_cmd_scheduler.sv - PS/2 make-code decoder, request queue and one-at-a-time sensor sequencer
//
// Purpose: filters F0/E0 prefixed bytes, decodes make codes into temperature/smoke
// requests, queues them in a small FIFO and runs one sensor operation at a time with
// an enable/done handshake guarded by a timeout.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    sensor_cmd_if.slave (datolisto, tecla, temp_done, humo_done in;
//          tempenable, humoenable, busy, cor out)

module sensor_cmd_scheduler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TIMEOUT_CYC = 50000000,
    parameter logic [7:0] KEY_TEMP    = 8'h2C,
    parameter logic [7:0] KEY_HUMO    = 8'h33,
    parameter logic [7:0] KEY_ALL     = 8'h1C,
    parameter logic [7:0] KEY_ABORT   = 8'h76
) (
    input  logic         clk,
    input  logic         reset,
    sensor_cmd_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, TEMP, HUMO} state_t;

    state_t          r_state, w_state_nxt;
    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_brk, r_ext;
    logic            r_ovf, r_tout;
    logic            r_tempenable, r_humoenable;
    logic [TW-1:0]   r_tcnt;

    logic            w_prefix, w_decode;
    logic            w_key_temp, w_key_humo, w_key_all, w_key_abort;
    logic [AW:0]     w_free, w_npush;
    logic            w_push1, w_push2, w_ovf_set;
    logic            w_pop, w_tout_set, w_head;

    // Decode only bytes that arrive with no pending break/extended prefix.
    assign w_prefix    = (bus.tecla == 8'hF0) || (bus.tecla == 8'hE0);
    assign w_decode    = bus.datolisto && !w_prefix && !r_brk && !r_ext;
    assign w_key_temp  = w_decode && (bus.tecla == KEY_TEMP);
    assign w_key_humo  = w_decode && (bus.tecla == KEY_HUMO);
    assign w_key_all   = w_decode && (bus.tecla == KEY_ALL);
    assign w_key_abort = w_decode && (bus.tecla == KEY_ABORT);

    // Room is judged on the registered count, so a pop in this cycle never frees space.
    assign w_free    = DEPTH_V - r_count;
    assign w_push1   = (w_key_temp || w_key_humo) && (w_free != '0);
    assign w_push2   = w_key_all && (w_free >= (AW+1)'(2));
    assign w_ovf_set = (w_key_temp || w_key_humo || w_key_all) && !w_push1 && !w_push2;
    assign w_npush   = w_push2 ? (AW+1)'(2) : (w_push1 ? (AW+1)'(1) : '0);
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tout_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head ? HUMO : TEMP;
                end
            end
            TEMP: begin
                // done is checked first so a done on the last allowed cycle is not an error
                if (bus.temp_done) begin
                    w_state_nxt = IDLE;
                end else if (r_tcnt == TMAX) begin
                    w_state_nxt = IDLE;
                    w_tout_set  = 1'b1;
                end
            end
            HUMO: begin
                if (bus.humo_done) begin
                    w_state_nxt = IDLE;
                end else if (r_tcnt == TMAX) begin
                    w_state_nxt = IDLE;
                    w_tout_set  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_key_abort) begin
            w_state_nxt = IDLE;
            w_pop       = 1'b0;
            w_tout_set  = 1'b0;
        end
    end

    // Counter restarts whenever the state changes, so it reads 0 on the first op cycle.
    always_ff @(posedge clk) begin
        if (reset || r_state == IDLE || w_state_nxt != r_state) r_tcnt <= '0;
        else                                                    r_tcnt <= r_tcnt + TW'(1);
    end

    // Enables mirror the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tempenable <= 1'b0;
            r_humoenable <= 1'b0;
        end else begin
            r_tempenable <= (w_state_nxt == TEMP);
            r_humoenable <= (w_state_nxt == HUMO);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (bus.datolisto) begin
            if (bus.tecla == 8'hF0)      r_brk <= 1'b1;
            else if (bus.tecla == 8'hE0) r_ext <= 1'b1;
            else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_key_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push1) begin
                r_mem[r_wr_ptr] <= w_key_humo;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end else if (w_push2) begin
                r_mem[r_wr_ptr]          <= 1'b0;
                r_mem[r_wr_ptr + AW'(1)] <= 1'b1;
                r_wr_ptr                 <= r_wr_ptr + AW'(2);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + w_npush - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_key_abort) begin
            r_ovf  <= 1'b0;
            r_tout <= 1'b0;
        end else begin
            r_ovf  <= r_ovf  | w_ovf_set;
            r_tout <= r_tout | w_tout_set;
        end
    end

    assign bus.tempenable = r_tempenable;
    assign bus.humoenable = r_humoenable;
    assign bus.busy       = (r_state != IDLE) || (r_count != '0);
    assign bus.cor        = {r_ovf, r_tout, r_humoenable, r_tempenable};

endmodule

// File: tb/tb_sensor_cmd_scheduler.sv
// tb/tb_sensor_cmd_scheduler.sv - directed self-checking bench for sensor_cmd_scheduler

module tb_sensor_cmd_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    sensor_cmd_if bus();

    sensor_cmd_scheduler #(
        .FIFO_DEPTH (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] b);
        bus.datolisto = 1'b1;
        bus.tecla     = b;
        step();
        bus.datolisto = 1'b0;
        bus.tecla     = 8'h00;
    endtask

    task automatic pulse_temp_done();
        bus.temp_done = 1'b1;
        step();
        bus.temp_done = 1'b0;
    endtask

    task automatic pulse_humo_done();
        bus.humo_done = 1'b1;
        step();
        bus.humo_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_total++; if (bus.tempenable !== 1'b0) $display("FAIL reset_tempenable got %b exp 0", bus.tempenable); else n_pass++;
        n_total++; if (bus.humoenable !== 1'b0) $display("FAIL reset_humoenable got %b exp 0", bus.humoenable); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
        n_total++; if (bus.cor !== 4'b0000) $display("FAIL reset_cor got %b exp 0000", bus.cor); else n_pass++;
    endtask

    task automatic test_basic_temp();
        send_key(8'h2C);
        n_total++; if (bus.tempenable !== 1'b0) $display("FAIL basic_en_n1 got %b exp 0", bus.tempenable); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_n1 got %b exp 1", bus.busy); else n_pass++;
        step();
        n_total++; if (bus.tempenable !== 1'b1) $display("FAIL basic_en_n2 got %b exp 1", bus.tempenable); else n_pass++;
        n_total++; if (bus.cor !== 4'b0001) $display("FAIL basic_cor_active got %b exp 0001", bus.cor); else n_pass++;
        pulse_temp_done();
        n_total++; if (bus.tempenable !== 1'b0) $display("FAIL basic_en_after_done got %b exp 0", bus.tempenable); else n_pass++;
        n_total++; if (bus.cor !== 4'b0000) $display("FAIL basic_cor_after got %b exp 0000", bus.cor); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_key(8'h1C);
        step();
        n_total++; if (bus.cor[1:0] !== 2'b01) $display("FAIL b2b_first_temp got %b exp 01", bus.cor[1:0]); else n_pass++;
        pulse_temp_done();
        n_total++; if (bus.cor[1:0] !== 2'b00) $display("FAIL b2b_gap got %b exp 00", bus.cor[1:0]); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b_gap_busy got %b exp 1", bus.busy); else n_pass++;
        step();
        n_total++; if (bus.cor[1:0] !== 2'b10) $display("FAIL b2b_second_humo got %b exp 10", bus.cor[1:0]); else n_pass++;
        pulse_humo_done();
        n_total++; if (bus.humoenable !== 1'b0) $display("FAIL b2b_humo_off got %b exp 0", bus.humoenable); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_end got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_prefix();
        send_key(8'hF0);
        send_key(8'h2C);
        send_key(8'hE0);
        send_key(8'h33);
        for (int i = 0; i < 3; i++) begin
            n_total++; if ({bus.busy, bus.humoenable, bus.tempenable} !== 3'b000) $display("FAIL prefix_idle_%0d got %b exp 000", i, {bus.busy, bus.humoenable, bus.tempenable}); else n_pass++;
            step();
        end
        send_key(8'h33);
        step();
        n_total++; if (bus.humoenable !== 1'b1) $display("FAIL prefix_make_after got %b exp 1", bus.humoenable); else n_pass++;
        pulse_humo_done();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL prefix_busy_end got %b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_timeout();
        int hi;
        send_key(8'h33);
        step();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.humoenable !== 1'b1) break;
            hi++;
            step();
        end
        n_total++; if (hi != 16) $display("FAIL tout_high_cycles got %0d exp 16", hi); else n_pass++;
        n_total++; if (bus.cor !== 4'b0100) $display("FAIL tout_cor got %b exp 0100", bus.cor); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL tout_busy got %b exp 0", bus.busy); else n_pass++;
        send_key(8'h76);
        n_total++; if (bus.cor !== 4'b0000) $display("FAIL tout_abort_clear got %b exp 0000", bus.cor); else n_pass++;
    endtask

    task automatic test_overflow();
        send_key(8'h2C);
        step();
        send_key(8'h2C);
        send_key(8'h33);
        send_key(8'h2C);
        send_key(8'h33);
        n_total++; if (bus.cor !== 4'b0001) $display("FAIL ovf_full_no_err got %b exp 0001", bus.cor); else n_pass++;
        send_key(8'h33);
        n_total++; if (bus.cor !== 4'b1001) $display("FAIL ovf_fifth_drop got %b exp 1001", bus.cor); else n_pass++;
        // done, then a push in the pop cycle of a full queue must be dropped
        pulse_temp_done();
        send_key(8'h33);
        n_total++; if (bus.tempenable !== 1'b1) $display("FAIL ovf_next_temp got %b exp 1", bus.tempenable); else n_pass++;
        // one slot free: the two-entry request must be dropped
        send_key(8'h1C);
        pulse_temp_done();
        step();
        n_total++; if (bus.cor[1:0] !== 2'b10) $display("FAIL ovf_drain1 got %b exp 10", bus.cor[1:0]); else n_pass++;
        pulse_humo_done();
        step();
        n_total++; if (bus.cor[1:0] !== 2'b01) $display("FAIL ovf_drain2 got %b exp 01", bus.cor[1:0]); else n_pass++;
        pulse_temp_done();
        step();
        n_total++; if (bus.cor[1:0] !== 2'b10) $display("FAIL ovf_drain3 got %b exp 10", bus.cor[1:0]); else n_pass++;
        pulse_humo_done();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL ovf_drain_empty got %b exp 0", bus.busy); else n_pass++;
        n_total++; if (bus.cor !== 4'b1000) $display("FAIL ovf_sticky_kept got %b exp 1000", bus.cor); else n_pass++;
    endtask

    task automatic test_abort();
        send_key(8'h2C);
        step();
        send_key(8'h33);
        send_key(8'h2C);
        n_total++; if (bus.cor !== 4'b1001) $display("FAIL abort_pre got %b exp 1001", bus.cor); else n_pass++;
        bus.datolisto = 1'b1;
        bus.tecla     = 8'h76;
        bus.temp_done = 1'b1;
        step();
        bus.datolisto = 1'b0;
        bus.tecla     = 8'h00;
        bus.temp_done = 1'b0;
        n_total++; if (bus.cor !== 4'b0000) $display("FAIL abort_cor got %b exp 0000", bus.cor); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else n_pass++;
        step();
        step();
        n_total++; if (bus.cor !== 4'b0000) $display("FAIL abort_stays_idle got %b exp 0000", bus.cor); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_key(8'h2C);
        step();
        send_key(8'h33);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if ({bus.busy, bus.cor} !== 5'b00000) $display("FAIL rstmid_out got %b exp 00000", {bus.busy, bus.cor}); else n_pass++;
        step();
        step();
        n_total++; if ({bus.busy, bus.cor} !== 5'b00000) $display("FAIL rstmid_queue_flushed got %b exp 00000", {bus.busy, bus.cor}); else n_pass++;
    endtask

    initial begin
        bus.datolisto = 1'b0;
        bus.tecla     = 8'h00;
        bus.temp_done = 1'b0;
        bus.humo_done = 1'b0;
        #1;
        test_reset();
        test_basic_temp();
        test_back_to_back();
        test_prefix();
        test_timeout();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
